// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM state and bus-owner encodings
package mem_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;
  typedef enum logic {
    OWN_IFU = 1'b0,
    OWN_LSU = 1'b1
  } owner_e;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: ifu, lsu and memory-side signals of the shared memory port
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              ifu_req_i;
  logic [ADDR_W-1:0] ifu_addr_i;
  logic              ifu_gnt_o;
  logic              ifu_rvalid_o;
  logic [DATA_W-1:0] ifu_rdata_o;
  logic              ifu_err_o;
  logic              lsu_req_i;
  logic              lsu_we_i;
  logic [ADDR_W-1:0] lsu_addr_i;
  logic [DATA_W-1:0] lsu_wdata_i;
  logic [DATA_W/8-1:0] lsu_wmask_i;
  logic              lsu_gnt_o;
  logic              lsu_rvalid_o;
  logic [DATA_W-1:0] lsu_rdata_o;
  logic              lsu_err_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W/8-1:0] mem_wmask_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  modport slave (
    input  ifu_req_i, ifu_addr_i,
    input  lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_wmask_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o, ifu_err_o,
    output lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o
  );
  modport master (
    output ifu_req_i, ifu_addr_i,
    output lsu_req_i, lsu_we_i, lsu_addr_i, lsu_wdata_i, lsu_wmask_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  ifu_gnt_o, ifu_rvalid_o, ifu_rdata_o, ifu_err_o,
    input  lsu_gnt_o, lsu_rvalid_o, lsu_rdata_o, lsu_err_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o
  );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// rr_arb2: two-requester round-robin arbiter, ties go to the unit not granted last
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);
  owner_e last_q, last_d;
  always_comb begin
    gnt = &req ? (last_q == OWN_IFU ? 2'b10 : 2'b01) : req;
    last_d = (en && |req) ? (gnt[1] ? OWN_LSU : OWN_IFU) : last_q;
  end
  always_ff @(posedge clk) begin
    if (rst) last_q <= OWN_IFU;
    else last_q <= last_d;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between ifu and lsu, one transaction at a time, with timeout
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(TIMEOUT);
  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;
  logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;
  logic                ifu_err_q, ifu_err_d, lsu_err_q, lsu_err_d;
  logic [1:0]          arb_gnt, gnt;
  logic                busy, done, tmo, fin;
  rr_arb2 u_arb (
    .clk (clk),
    .rst (rst),
    .req ({bus.lsu_req_i, bus.ifu_req_i}),
    .en  (state_q == ST_IDLE),
    .gnt (arb_gnt)
  );
  assign gnt = arb_gnt & {2{state_q == ST_IDLE}};
  assign bus.ifu_gnt_o    = gnt[0];
  assign bus.lsu_gnt_o    = gnt[1];
  assign bus.ifu_rvalid_o = state_q == ST_RESP && owner_q == OWN_IFU;
  assign bus.lsu_rvalid_o = state_q == ST_RESP && owner_q == OWN_LSU;
  assign bus.ifu_rdata_o  = ifu_rdata_q;
  assign bus.lsu_rdata_o  = lsu_rdata_q;
  assign bus.ifu_err_o    = ifu_err_q;
  assign bus.lsu_err_o    = lsu_err_q;
  assign bus.mem_req_o    = state_q == ST_ADDR;
  assign bus.mem_we_o     = we_q;
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_wdata_o  = wdata_q;
  assign bus.mem_wmask_o  = wmask_q;
  always_comb begin
    busy = state_q == ST_ADDR || state_q == ST_WAIT;
    done = bus.mem_rvalid_i && (state_q == ST_WAIT || (state_q == ST_ADDR && bus.mem_gnt_i));
    tmo = busy && cnt_q == CNT_W'(TIMEOUT - 1);
    fin = done || tmo;
    state_d = state_q;
    owner_d = owner_q;
    cnt_d = busy ? cnt_q + CNT_W'(1) : '0;
    we_d = we_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    ifu_rdata_d = ifu_rdata_q;
    ifu_err_d = ifu_err_q;
    lsu_rdata_d = lsu_rdata_q;
    lsu_err_d = lsu_err_q;
    unique case (state_q)
      ST_IDLE: if (|gnt) begin
        state_d = ST_ADDR;
        owner_d = gnt[1] ? OWN_LSU : OWN_IFU;
        we_d = gnt[1] & bus.lsu_we_i;
        addr_d = gnt[1] ? bus.lsu_addr_i : bus.ifu_addr_i;
        wdata_d = gnt[1] ? bus.lsu_wdata_i : '0;
        wmask_d = gnt[1] ? bus.lsu_wmask_i : '0;
      end
      ST_ADDR: state_d = fin ? ST_RESP : bus.mem_gnt_i ? ST_WAIT : ST_ADDR;
      ST_WAIT: state_d = fin ? ST_RESP : ST_WAIT;
      default: state_d = ST_IDLE;
    endcase
    if (fin && owner_q == OWN_LSU) begin
      lsu_rdata_d = done ? bus.mem_rdata_i : '0;
      lsu_err_d = !done;
    end
    if (fin && owner_q == OWN_IFU) begin
      ifu_rdata_d = done ? bus.mem_rdata_i : '0;
      ifu_err_d = !done;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IFU;
      cnt_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      ifu_rdata_q <= '0;
      ifu_err_q <= 1'b0;
      lsu_rdata_q <= '0;
      lsu_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
      ifu_rdata_q <= ifu_rdata_d;
      ifu_err_q <= ifu_err_d;
      lsu_rdata_q <= lsu_rdata_d;
      lsu_err_q <= lsu_err_d;
    end
  end
endmodule
